// File: rtl/codificacao_pkg.sv
// Shared definitions for the 4-bit Gray coding system (encoder/decoder pair).
package codificacao_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        EST_IDLE   = 2'd0,
        EST_DECODE = 2'd1,
        EST_DONE   = 2'd2
    } estado_t;

    // Whole-word Gray-to-binary conversion, handy as a reference in benches.
    function automatic logic [CODE_W-1:0] gray_para_bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Registered rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;
    logic sinal_d;

    // Next value of the delayed copy is simply the current input.
    always_comb begin
        sinal_d = sinal;
    end

    // Delayed copy clears on reset so an input already high right after release counts as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal_d;
        end
    end

    assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/decodificador_gray.sv
// Serial Gray-to-binary decoder: captures S3..S0 on a rising edge of ready,
// rebuilds the binary word MSB first (one bit per clock), then pulses valid.
module decodificador_gray
    import codificacao_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               S3,
    input  logic               S2,
    input  logic               S1,
    input  logic               S0,
    input  logic               ready,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               D,
    output logic               valid,
    output logic               busy,
    output logic               overrun,
    output logic [COUNT_W-1:0] count
);

    estado_t              estado_q, estado_d;
    logic [CODE_W-1:0]    codigo_q, codigo_d;
    logic [CODE_W-1:0]    acc_q, acc_d;
    logic [1:0]           idx_q, idx_d;
    logic [CODE_W-1:0]    saida_q, saida_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 inicio;
    logic                 bit_novo;

    detector_borda u_borda (
        .clk   (clk),
        .reset (reset),
        .sinal (ready),
        .pulso (inicio)
    );

    // Current decoded bit: the MSB copies the Gray bit, lower bits XOR with the bit above.
    always_comb begin
        if (idx_q == 2'd3) begin
            bit_novo = codigo_q[3];
        end else begin
            bit_novo = acc_q[idx_q + 2'd1] ^ codigo_q[idx_q];
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        estado_d  = estado_q;
        codigo_d  = codigo_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        saida_d   = saida_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        count_d   = count_q;

        // A start edge while a word is in flight is dropped and flagged.
        if (inicio && (estado_q != EST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (estado_q)
            EST_IDLE: begin
                if (inicio) begin
                    codigo_d = {S3, S2, S1, S0};
                    acc_d    = '0;
                    idx_d    = 2'd3;
                    estado_d = EST_DECODE;
                end
            end
            EST_DECODE: begin
                acc_d[idx_q] = bit_novo;
                if (idx_q == 2'd0) begin
                    // Outputs, valid and count are committed on the edge into DONE,
                    // so they are all visible together during the DONE cycle.
                    saida_d  = {acc_q[3:1], bit_novo};
                    valid_d  = 1'b1;
                    count_d  = count_q + 1'b1;
                    estado_d = EST_DONE;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end
            EST_DONE: begin
                estado_d = EST_IDLE;
            end
            default: begin
                estado_d = EST_IDLE;
            end
        endcase
    end

    // State registers; reset wins over any event in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= EST_IDLE;
            codigo_q  <= '0;
            acc_q     <= '0;
            idx_q     <= 2'd0;
            saida_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            estado_q  <= estado_d;
            codigo_q  <= codigo_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            saida_q   <= saida_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign {A, B, C, D} = saida_q;
    assign valid        = valid_q;
    assign busy         = (estado_q != EST_IDLE);
    assign overrun      = overrun_q;
    assign count        = count_q;

endmodule

// File: tb/tb_decodificador_gray.sv
// Self-checking bench for decodificador_gray: directed scenarios plus randomized words,
// with a second instance at COUNT_W=2 to exercise counter wrap.
module tb_decodificador_gray;

    logic       clk;
    logic       reset;
    logic       S3, S2, S1, S0;
    logic       ready;
    logic       A, B, C, D, valid, busy, overrun;
    logic [7:0] count;
    logic       A2, B2, C2, D2, valid2, busy2, overrun2;
    logic [1:0] count2;

    int n_checks;
    int n_fail;

    // Reference state kept at transaction level.
    int         mdl_count;
    bit         mdl_overrun;
    logic [3:0] mdl_out;

    decodificador_gray #(.COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .S3(S3), .S2(S2), .S1(S1), .S0(S0), .ready(ready),
        .A(A), .B(B), .C(C), .D(D), .valid(valid), .busy(busy), .overrun(overrun),
        .count(count)
    );

    decodificador_gray #(.COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .S3(S3), .S2(S2), .S1(S1), .S0(S0), .ready(ready),
        .A(A2), .B(B2), .C(C2), .D(D2), .valid(valid2), .busy(busy2), .overrun(overrun2),
        .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Binary value of a Gray word: b = g ^ (g>>1) ^ (g>>2) ^ (g>>3).
    function automatic logic [3:0] bin_de_gray(input int g);
        int b;
        b = 0;
        for (int s = 0; s < 4; s++) b = b ^ (g >> s);
        return 4'(b & 15);
    endfunction

    function automatic logic [3:0] gray_de_bin(input int v);
        return 4'((v ^ (v >> 1)) & 15);
    endfunction

    task automatic set_code(input logic [3:0] c);
        {S3, S2, S1, S0} = c;
    endtask

    task automatic check_idle_all(input string tag);
        check_val({tag, "_outs"}, {28'd0, A, B, C, D}, {28'd0, mdl_out});
        check_val({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_overrun"}, {31'd0, overrun}, {31'd0, mdl_overrun});
        check_val({tag, "_count"}, {24'd0, count}, 32'(mdl_count % 256));
        check_val({tag, "_count2"}, {30'd0, count2}, 32'(mdl_count % 4));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        mdl_count   = 0;
        mdl_overrun = 1'b0;
        mdl_out     = 4'd0;
    endtask

    // Called at a negedge with the DUT idle and ready low. Raises ready with the code,
    // keeps ready high for 'hold' sampling edges, optionally scrambles S during the decode.
    task automatic run_word(input logic [3:0] code, input int hold, input bit scramble);
        logic [3:0] exp_out;
        int extra;
        exp_out = bin_de_gray(int'(code));
        set_code(code);
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("busy_decode", {31'd0, busy}, 32'd1);
            check_val("valid_timing", {31'd0, valid}, (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) begin
                check_val("no_partial", {28'd0, A, B, C, D}, {28'd0, mdl_out});
            end else begin
                mdl_count++;
                mdl_out = exp_out;
                check_val("decoded", {28'd0, A, B, C, D}, {28'd0, exp_out});
                check_val("decoded_w2", {28'd0, A2, B2, C2, D2}, {28'd0, exp_out});
                check_val("count", {24'd0, count}, 32'(mdl_count % 256));
                check_val("count_w2", {30'd0, count2}, 32'(mdl_count % 4));
                check_val("overrun_keep", {31'd0, overrun}, {31'd0, mdl_overrun});
            end
            if (scramble) set_code(4'($urandom_range(0, 15)));
            ready = (k + 1 < hold);
        end
        extra = (hold > 5) ? hold - 5 : 0;
        for (int j = 0; j < extra; j++) begin
            @(negedge clk);
            check_val("hold_no_retrigger_valid", {31'd0, valid}, 32'd0);
            check_val("hold_no_retrigger_busy", {31'd0, busy}, 32'd0);
            ready = (5 + j + 1 < hold);
        end
        @(negedge clk);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        check_val("idle_valid", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        logic [1:0] exp_c2 [5];
        n_checks    = 0;
        n_fail      = 0;
        mdl_count   = 0;
        mdl_overrun = 1'b0;
        mdl_out     = 4'd0;
        reset = 1'b1;
        ready = 1'b0;
        set_code(4'd0);

        // 1. Reset state
        do_reset(3);
        check_idle_all("reset");

        // 2. Single word 1100 -> 1000
        run_word(4'b1100, 1, 1'b0);
        check_val("first_word", {28'd0, A, B, C, D}, 32'b1000);

        // 3. Sweep all Gray codes in order, then one word with ready held high
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            run_word(gray_de_bin(i), 1, 1'b0);
            check_val("sweep_value", {28'd0, A, B, C, D}, 32'(i));
        end
        check_val("sweep_count", {24'd0, count}, 32'd16);
        run_word(4'b0101, 11, 1'b0);

        // 4. Overrun: second edge while busy is ignored
        set_code(4'b0111);
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("ovr_busy", {31'd0, busy}, 32'd1);
            if (k == 2) check_val("ovr_flag_set", {31'd0, overrun}, 32'd1);
            if (k == 4) begin
                check_val("ovr_valid", {31'd0, valid}, 32'd1);
                check_val("ovr_decoded", {28'd0, A, B, C, D}, 32'b0101);
            end
            if (k == 0) ready = 1'b0;
            if (k == 1) begin
                set_code(4'b0000);
                ready = 1'b1;
            end
            if (k == 4) ready = 1'b0;
        end
        mdl_count++;
        mdl_overrun = 1'b1;
        mdl_out     = 4'b0101;
        repeat (3) @(negedge clk);
        check_idle_all("ovr_after");
        run_word(4'b1011, 1, 1'b0);
        check_val("ovr_sticky", {31'd0, overrun}, 32'd1);

        // 5. Reset in the middle of a decode
        set_code(4'b1010);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_count   = 0;
        mdl_overrun = 1'b0;
        mdl_out     = 4'd0;
        check_idle_all("midreset");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val("midreset_no_valid", {31'd0, valid}, 32'd0);
            check_val("midreset_idle", {31'd0, busy}, 32'd0);
        end
        check_idle_all("midreset_end");

        // 6. Narrow counter wraps: 1, 2, 3, 0, 1
        exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            run_word(4'($urandom_range(0, 15)), 1, 1'b0);
            check_val("wrap_count2", {30'd0, count2}, {30'd0, exp_c2[i]});
        end

        // Randomized words: random codes, hold lengths, input noise and idle gaps
        for (int i = 0; i < 40; i++) begin
            run_word(4'($urandom_range(0, 15)), int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check_idle_all("random_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
